m_hazard_ctrl: RTL
==================

# m_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS-subset processor. It sits beside the ID stage. It keeps a 3-entry scoreboard of in-flight register writers (EX, ME, WB) and stalls IF/ID while a read-after-write hazard exists. It also squashes the IF/ID slot on a taken branch when configured to, and sequences HALT through a drain phase before asserting halt. Programs no longer need hand-inserted NOPs for data dependencies.

## Interface
- FLUSH_SLOT, 0: 1 = squash the instruction behind a taken branch; 0 = keep MIPS delay-slot semantics.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- w_clk  in  1  clock; all state updates on posedge.
- w_rst  in  1  synchronous, active-high reset.
- w_id_op  in  6  opcode of the instruction in ID.
- w_id_rs  in  5  rs field in ID.
- w_id_rt  in  5  rt field in ID.
- w_id_rd2  in  5  destination register of the ID instruction.
- w_id_w  in  1  ID instruction writes the register file.
- w_taken  in  1  branch taken, resolved in ID.
- w_stall  out  1  hold r_pc and IfId regs; combinational.
- w_bubble  out  1  load a NOP (op 0, w=0, we=0) into IdEx; equals w_stall.
- w_flush  out  1  replace the next IfId instruction with a NOP; combinational.
- w_fetch_en  out  1  PC may advance; low in DRAIN and HALT.
- r_halt  out  1  processor halted.
- r_state  out  2  0 RUN, 1 DRAIN, 2 HALT.
- r_stall_cnt  out  CNT_W  total stall cycles, saturating.

## Operation
- **Scoreboard.** Three entries sb_ex, sb_me, sb_wb, each holding {v, rd}. On every posedge:
  - sb_wb <= sb_me and sb_me <= sb_ex.
  - sb_ex <= {w_id_w & (w_id_rd2!=0) & ~w_stall & state==RUN, w_id_rd2}.
  - A bubble therefore enters sb_ex as invalid.
- **Source usage.**
  - rs is read by ops 0, 4, 5, 8, 0x23, 0x2b.
  - rt is read by ops 0, 4, 5, 0x2b.
  - HALT (0x11) and all other ops read no source.
  - Register 0 never causes a hazard.
- **Stall condition.** w_stall = state==RUN & (hit(rs) | hit(rt)).
  - hit(x) = x used & x!=0 & (any valid scoreboard entry has rd==x).
  - The WB entry counts as a hit because the register file is written at the end of the WB cycle.
- **Flush.** w_flush = FLUSH_SLOT & w_taken & ~w_stall & state==RUN. A branch that is stalled is not resolved until its operands are clean.
- **FSM.**
  - RUN -> DRAIN when w_id_op==0x11 & ~w_stall. HALT itself enters sb_ex as invalid.
  - DRAIN: w_fetch_en=0. Stays in DRAIN until all three entries are invalid, then goes to HALT.
  - HALT: r_halt=1, w_fetch_en=0. Absorbing; only w_rst leaves it.
  - w_fetch_en = state==RUN & ~w_stall.
- **Stall counter.** r_stall_cnt increments by 1 on each cycle with w_stall=1 and holds at 2^CNT_W-1.
- **Reset.** w_rst has priority over every other event. It clears the scoreboard, sets state RUN, r_halt=0 and r_stall_cnt=0. Reset mid-stall or mid-drain takes effect at the next edge.

## Timing
- **Reset values.** r_halt=0, r_state=0, r_stall_cnt=0. With scoreboard empty: w_stall=0, w_bubble=0, w_flush=0, w_fetch_en=1.
- **Stall length for a RAW dependency at distance d** (1 = adjacent instructions): 4-d cycles for d<=3, 0 for d>=4.
- **Combinational outputs.** Outputs depend only on scoreboard registers, state and ID inputs. They must settle within the same cycle, with no extra pipeline stage.
- **Stall and branch together.** The stall wins: no flush until the stall clears. The branch is then re-evaluated with correct operands.
- **HALT to r_halt.** r_halt rises at most 3 cycles after HALT leaves ID (scoreboard drain), and at least 1 cycle after.
- **Simultaneous hits.** The EX, ME and WB entries may all hit; the stall stays a single level. No double count.

## Test plan
- **Reset values.** Assert w_rst for 2 cycles with any inputs -> r_state=0, r_halt=0, r_stall_cnt=0, w_fetch_en=1.
- **Adjacent dependency.** addi $9,$0,1 then addi $9,$9,1 -> w_stall=1 for exactly 3 cycles, r_stall_cnt=3, second add reads 1; write to $0 then read $0 -> 0 stalls.
- **Distance and field use.**
  - Distance 3, using sw $11 after a write of $11 -> 1 stall cycle.
  - Distance 4 -> 0 stall cycles.
  - lw $11 reading an rt that matches an in-flight rd -> no stall.
- **Taken branch.**
  - bne $8,$9 with $9 written one instruction earlier and the branch taken -> 3 stall cycles, then with FLUSH_SLOT=1 w_flush=1 for 1 cycle.
  - With FLUSH_SLOT=0 -> w_flush stays 0.
- **HALT drain.** HALT directly after addi $30 -> state DRAIN for 3 cycles, then HALT, r_halt=1, w_fetch_en=0 held indefinitely.
- **Reset during DRAIN and counter saturation.**
  - w_rst during DRAIN -> next cycle state RUN, scoreboard empty.
  - With CNT_W=2 and 5 stall cycles -> r_stall_cnt=3.

Source files
------------

// File: rtl/m_hazard_ctrl.sv
// Hazard/sequencing controller beside ID: 3-entry writer scoreboard (EX/ME/WB),
// RAW stall, optional branch-slot squash, and HALT drain sequencing.
module m_hazard_ctrl #(
  parameter bit FLUSH_SLOT = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic [5:0]       w_id_op,
  input  logic [4:0]       w_id_rs,
  input  logic [4:0]       w_id_rt,
  input  logic [4:0]       w_id_rd2,
  input  logic             w_id_w,
  input  logic             w_taken,
  output logic             w_stall,
  output logic             w_bubble,
  output logic             w_flush,
  output logic             w_fetch_en,
  output logic             r_halt,
  output logic [1:0]       r_state,
  output logic [CNT_W-1:0] r_stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_entry_t;

  localparam logic [5:0] OP_HALT = 6'h11;

  state_t    state, next_state;
  sb_entry_t sb_ex, sb_me, sb_wb;
  logic      use_rs, use_rt, hazard, sb_empty;

  // Register 0 is hardwired, so it never matches an in-flight writer.
  function automatic logic hit(input logic [4:0] x, input sb_entry_t a,
                               input sb_entry_t b, input sb_entry_t c);
    return (x != 5'd0) && ((a.v && a.rd == x) || (b.v && b.rd == x) ||
                           (c.v && c.rd == x));
  endfunction

  // NOTE: every variable driven in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (w_id_op)
      6'h00, 6'h04, 6'h05, 6'h2b: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      6'h08, 6'h23: use_rs = 1'b1;
      default: ;
    endcase
  end

  assign sb_empty = !sb_ex.v && !sb_me.v && !sb_wb.v;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge w_clk) begin
    if (w_rst) state <= RUN;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (w_id_op == OP_HALT && !w_stall) next_state = DRAIN;
      DRAIN:   if (sb_empty) next_state = HALT;
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase
  end

  // Output logic: purely combinational from scoreboard, state and ID fields.
  always_comb begin
    hazard     = (use_rs && hit(w_id_rs, sb_ex, sb_me, sb_wb)) ||
                 (use_rt && hit(w_id_rt, sb_ex, sb_me, sb_wb));
    w_stall    = (state == RUN) && hazard;
    w_bubble   = w_stall;
    w_flush    = FLUSH_SLOT && w_taken && !w_stall && (state == RUN);
    w_fetch_en = (state == RUN) && !w_stall;
  end

  assign r_state = state;

  // Scoreboard shift, halt flag and saturating stall counter.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      sb_ex       <= '0;
      sb_me       <= '0;
      sb_wb       <= '0;
      r_halt      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      sb_wb    <= sb_me;
      sb_me    <= sb_ex;
      sb_ex.v  <= w_id_w && (w_id_rd2 != 5'd0) && !w_stall && (state == RUN);
      sb_ex.rd <= w_id_rd2;
      r_halt   <= (next_state == HALT);
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule
